// File: rtl/frame_arbiter_pkg.sv
// Shared constants and clear-sequencer state type for the frame-buffer arbiter.
package frame_arbiter_pkg;
  localparam int FA_H_ACTIVE    = 640;
  localparam int FA_V_ACTIVE    = 480;
  localparam int FA_PIX_W       = 4;
  localparam int FA_ADDR_W      = 18;
  localparam int FA_WORDS       = FA_H_ACTIVE * FA_V_ACTIVE / 2;
  // 320 words per line = 256 + 64, built from two shifts instead of a multiplier
  localparam int FA_LINE_SH_HI  = 8;
  localparam int FA_LINE_SH_LO  = 6;
  localparam int FA_LINE_STRIDE = (1 << FA_LINE_SH_HI) + (1 << FA_LINE_SH_LO);
  localparam int FA_PIPE_LAT    = 3;

  typedef enum logic {
    CLR_IDLE = 1'b0,
    CLR_RUN  = 1'b1
  } clr_state_t;
endpackage

// File: rtl/frame_arbiter_sync_delay.sv
// N-stage shift register with a per-stage reset value; aligns blank/syncs to the pixel pipe.
module frame_arbiter_sync_delay #(
  parameter int           N       = 3,
  parameter logic [N-1:0] RST_VAL = '1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);
  logic [N-1:0] r_sr;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_sr <= RST_VAL;
    else       r_sr <= {r_sr[N-2:0], i_d};
  end

  assign o_q = r_sr[N-1];
endmodule

// File: rtl/frame_arbiter.sv
// Single-port frame-buffer scheduler: display fetch on even active pixels, writer/clear
// accesses in every other slot, 4-bit pixel unpack and matching blank/sync delay.
module frame_arbiter
  import frame_arbiter_pkg::*;
#(
  parameter int H_ACTIVE = FA_H_ACTIVE,
  parameter int V_ACTIVE = FA_V_ACTIVE,
  parameter int PIX_W    = FA_PIX_W,
  parameter int ADDR_W   = FA_ADDR_W,
  parameter int WORDS    = FA_WORDS
) (
  input  logic                 vclock,
  input  logic                 reset,
  input  logic [9:0]           hcount,
  input  logic [9:0]           vcount,
  input  logic                 hsync,
  input  logic                 vsync,
  input  logic                 blank,
  input  logic                 wr_req,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [2*PIX_W-1:0]   wr_data,
  output logic                 wr_ack,
  input  logic                 clear_req,
  output logic                 clear_busy,
  output logic                 clear_done,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic                 mem_we,
  output logic [2*PIX_W-1:0]   mem_din,
  input  logic [2*PIX_W-1:0]   mem_dout,
  output logic [PIX_W-1:0]     pixel,
  output logic                 blank_out,
  output logic                 hsync_out,
  output logic                 vsync_out
);
  localparam int                DW     = 2 * PIX_W;
  localparam logic [9:0]        H_LIM  = 10'(H_ACTIVE);
  localparam logic [9:0]        V_LIM  = 10'(V_ACTIVE);
  localparam logic [ADDR_W-1:0] W_LIM  = ADDR_W'(WORDS);
  localparam logic [ADDR_W-1:0] W_LAST = ADDR_W'(WORDS - 1);

  clr_state_t        r_state, w_state_nx;
  logic [ADDR_W-1:0] r_clr_ptr, w_clr_ptr_nx;
  logic [ADDR_W-1:0] r_mem_addr, w_addr_nx;
  logic              r_mem_we, w_we_nx;
  logic [DW-1:0]     r_mem_din, w_din_nx;
  logic              r_wr_ack, w_ack_nx;
  logic              r_clear_done, w_done_nx;
  logic              w_active, w_disp_slot;
  logic [ADDR_W-1:0] w_fetch_addr;
  logic              r_ev1, r_od1, r_ev2, r_od2;
  logic [DW-1:0]     r_hold;
  logic [PIX_W-1:0]  r_pixel;

  assign w_active     = (vcount < V_LIM) && (hcount < H_LIM);
  assign w_disp_slot  = w_active && !hcount[0];
  assign w_fetch_addr = (ADDR_W'(vcount) << FA_LINE_SH_HI) + (ADDR_W'(vcount) << FA_LINE_SH_LO)
                      + ADDR_W'(hcount[9:1]);

  always_comb begin
    w_state_nx   = r_state;
    w_clr_ptr_nx = r_clr_ptr;
    w_addr_nx    = r_mem_addr;
    w_we_nx      = 1'b0;
    w_din_nx     = r_mem_din;
    w_ack_nx     = 1'b0;
    w_done_nx    = 1'b0;

    if (r_state == CLR_IDLE && clear_req) begin
      w_state_nx   = CLR_RUN;
      w_clr_ptr_nx = '0;
    end

    if (w_disp_slot) begin
      w_addr_nx = w_fetch_addr;
    end else if (r_state == CLR_RUN) begin
      w_addr_nx    = r_clr_ptr;
      w_we_nx      = 1'b1;
      w_din_nx     = '0;
      w_clr_ptr_nx = r_clr_ptr + 1'b1;
      if (r_clr_ptr == W_LAST) begin
        w_state_nx = CLR_IDLE;
        w_done_nx  = 1'b1;
      end
    end else if (wr_req && !r_wr_ack) begin
      // A request still high during its own ack cycle is the one just served
      w_ack_nx = 1'b1;
      if (wr_addr < W_LIM) begin
        w_we_nx   = 1'b1;
        w_addr_nx = wr_addr;
        w_din_nx  = wr_data;
      end
    end
  end

  always_ff @(posedge vclock or posedge reset) begin
    if (reset) begin
      r_state      <= CLR_IDLE;
      r_clr_ptr    <= '0;
      r_mem_addr   <= '0;
      r_mem_we     <= 1'b0;
      r_mem_din    <= '0;
      r_wr_ack     <= 1'b0;
      r_clear_done <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_clr_ptr    <= w_clr_ptr_nx;
      r_mem_addr   <= w_addr_nx;
      r_mem_we     <= w_we_nx;
      r_mem_din    <= w_din_nx;
      r_wr_ack     <= w_ack_nx;
      r_clear_done <= w_done_nx;
    end
  end

  always_ff @(posedge vclock or posedge reset) begin
    if (reset) begin
      r_ev1   <= 1'b0;
      r_od1   <= 1'b0;
      r_ev2   <= 1'b0;
      r_od2   <= 1'b0;
      r_hold  <= '0;
      r_pixel <= '0;
    end else begin
      r_ev1 <= w_disp_slot;
      r_od1 <= w_active && hcount[0];
      r_ev2 <= r_ev1;
      r_od2 <= r_od1;
      if (r_ev2) begin
        r_pixel <= mem_dout[PIX_W-1:0];
        r_hold  <= mem_dout;
      end else if (r_od2) begin
        r_pixel <= r_hold[DW-1:PIX_W];
      end else begin
        r_pixel <= '0;
      end
    end
  end

  frame_arbiter_sync_delay #(.N(FA_PIPE_LAT), .RST_VAL('1)) u_blank_dly (
    .i_clk(vclock), .i_rst(reset), .i_d(blank), .o_q(blank_out)
  );
  frame_arbiter_sync_delay #(.N(FA_PIPE_LAT), .RST_VAL('1)) u_hsync_dly (
    .i_clk(vclock), .i_rst(reset), .i_d(hsync), .o_q(hsync_out)
  );
  frame_arbiter_sync_delay #(.N(FA_PIPE_LAT), .RST_VAL('1)) u_vsync_dly (
    .i_clk(vclock), .i_rst(reset), .i_d(vsync), .o_q(vsync_out)
  );

  assign mem_addr   = r_mem_addr;
  assign mem_we     = r_mem_we;
  assign mem_din    = r_mem_din;
  assign wr_ack     = r_wr_ack;
  assign clear_busy = (r_state == CLR_RUN);
  assign clear_done = r_clear_done;
  assign pixel      = r_pixel;
endmodule

// File: tb/tb_frame_arbiter.sv
// Directed bench for frame_arbiter: RAM model, compressed timing generator, pixel scoreboard.
module tb_frame_arbiter;
  import frame_arbiter_pkg::*;

  localparam int AW       = 18;
  localparam int WORDS_TB = 1024;
  localparam int H_TOT    = 660;
  localparam int V_TOT    = 525;
  localparam int RAM_SZ   = 1 << AW;

  logic          vclock = 1'b0;
  logic          reset  = 1'b1;
  logic [9:0]    hcount = '0, vcount = '0;
  logic          hsync = 1'b1, vsync = 1'b1, blank = 1'b1;
  logic          wr_req = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [7:0]    wr_data = '0;
  logic          wr_ack, clear_busy, clear_done;
  logic          clear_req = 1'b0;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [7:0]    mem_din, mem_dout;
  logic [3:0]    pixel;
  logic          blank_out, hsync_out, vsync_out;

  frame_arbiter #(.WORDS(WORDS_TB)) dut (
    .vclock(vclock), .reset(reset), .hcount(hcount), .vcount(vcount),
    .hsync(hsync), .vsync(vsync), .blank(blank),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .clear_req(clear_req), .clear_busy(clear_busy), .clear_done(clear_done),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din), .mem_dout(mem_dout),
    .pixel(pixel), .blank_out(blank_out), .hsync_out(hsync_out), .vsync_out(vsync_out)
  );

  always #5 vclock = ~vclock;

  logic [7:0] ram [RAM_SZ];
  always @(posedge vclock) begin
    mem_dout <= ram[mem_addr];
    if (mem_we) ram[mem_addr] = mem_din;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int         due;
    logic [3:0] pix;
    logic       bl, hs, vs;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   h = 0, v = 0;
  bit   sb_en = 1'b0;

  always @(posedge vclock) cyc <= cyc + 1;

  always @(negedge vclock) begin : mon
    exp_t e;
    if (!reset) begin
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        chk("pixel",     32'(pixel),     32'(e.pix));
        chk("blank_out", 32'(blank_out), 32'(e.bl));
        chk("hsync_out", 32'(hsync_out), 32'(e.hs));
        chk("vsync_out", 32'(vsync_out), 32'(e.vs));
      end
    end
  end

  function automatic logic [3:0] exp_pix(input int hh, input int vv);
    logic [7:0] w;
    if (hh < FA_H_ACTIVE && vv < FA_V_ACTIVE) begin
      w = ram[vv * FA_LINE_STRIDE + hh / 2];
      return (hh % 2 == 1) ? w[7:4] : w[3:0];
    end
    return 4'h0;
  endfunction

  task automatic tick();
    exp_t e;
    hcount = 10'(h);
    vcount = 10'(v);
    blank  = !(h < FA_H_ACTIVE && v < FA_V_ACTIVE);
    hsync  = !(h >= 650 && h < 656);
    vsync  = !(v >= 490 && v < 492);
    if (sb_en) begin
      e.due = cyc + 3;
      e.pix = exp_pix(h, v);
      e.bl  = blank;
      e.hs  = hsync;
      e.vs  = vsync;
      sb.push_back(e);
    end
    @(posedge vclock);
    #1;
    h++;
    if (h == H_TOT) begin
      h = 0;
      v = (v == V_TOT - 1) ? 0 : v + 1;
    end
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_mem_addr"},   32'(mem_addr),   32'h0);
    chk({pfx, "_mem_we"},     32'(mem_we),     32'h0);
    chk({pfx, "_mem_din"},    32'(mem_din),    32'h0);
    chk({pfx, "_wr_ack"},     32'(wr_ack),     32'h0);
    chk({pfx, "_clear_busy"}, 32'(clear_busy), 32'h0);
    chk({pfx, "_clear_done"}, 32'(clear_done), 32'h0);
    chk({pfx, "_pixel"},      32'(pixel),      32'h0);
    chk({pfx, "_blank_out"},  32'(blank_out),  32'h1);
    chk({pfx, "_hsync_out"},  32'(hsync_out),  32'h1);
    chk({pfx, "_vsync_out"},  32'(vsync_out),  32'h1);
  endtask

  initial begin
    int          n, gh, k, zeros, dones, early_ack, nz, busy_seen;
    bit          got, acked;
    logic [7:0]  pre1024;
    int unsigned req_a [5];

    for (int i = 0; i < 16384; i++) ram[i] = 8'(i * 37 + (i >> 5));
    ram[0] = 8'hA5;
    ram[1] = 8'h3C;

    // reset state
    repeat (3) @(posedge vclock);
    #1;
    chk_reset_vals("rst");
    reset = 1'b0;

    // display fetch, line 0 and part of line 1 (pixels 0..3 expect 5,A,C,3)
    h = 0; v = 0; sb_en = 1'b1;
    repeat (700) tick();

    // writer request during active video
    h = 100; v = 0;
    wr_addr = AW'(1000); wr_data = 8'h5A; wr_req = 1'b1;
    n = 0; gh = 0; got = 1'b0;
    while (!got && n < 4) begin
      gh = h;
      tick();
      n++;
      if (wr_ack) got = 1'b1;
    end
    chk("act_ack_seen", 32'(got), 32'h1);
    chk("act_ack_wait", 32'(n), 32'd2);
    chk("act_slot_odd", 32'(gh % 2), 32'h1);
    chk("act_mem_we", 32'(mem_we), 32'h1);
    chk("act_mem_addr", 32'(mem_addr), 32'd1000);
    chk("act_mem_din", 32'(mem_din), 32'h5A);
    wr_req = 1'b0;
    repeat (4) tick();
    chk("act_ram_1000", 32'(ram[1000]), 32'h5A);

    // held request during vertical blanking; out-of-range addresses dropped
    req_a = '{200, 1023, 1024, 153600, 201};
    pre1024 = ram[1024];
    h = 0; v = 490; k = 0;
    wr_addr = AW'(req_a[0]); wr_data = 8'hC0; wr_req = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("blk_ack", 32'(wr_ack), 32'(c % 2 == 0));
      if (wr_ack && k < 5) begin
        chk("blk_we", 32'(mem_we), 32'(req_a[k] < WORDS_TB));
        if (req_a[k] < WORDS_TB) chk("blk_addr", 32'(mem_addr), req_a[k]);
        k++;
        if (k < 5) begin
          wr_addr = AW'(req_a[k]);
          wr_data = 8'hC0 + 8'(k);
        end else begin
          wr_req = 1'b0;
        end
      end
    end
    chk("blk_ram_200", 32'(ram[200]), 32'hC0);
    chk("blk_ram_1023", 32'(ram[1023]), 32'hC1);
    chk("blk_ram_1024", 32'(ram[1024]), 32'(pre1024));
    chk("blk_ram_201", 32'(ram[201]), 32'hC4);

    // frame clear with a competing writer and a repeated clear_req
    h = 0; v = 10;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    chk("clr_busy_rise", 32'(clear_busy), 32'h1);
    wr_addr = AW'(5); wr_data = 8'hFF; wr_req = 1'b1;
    zeros = 0; dones = 0; early_ack = 0; acked = 1'b0; n = 0;
    while (!acked && n < 4000) begin
      clear_req = (n == 100);
      tick();
      n++;
      if (mem_we && !wr_ack && mem_din == 8'h00) zeros++;
      if (clear_done) begin
        dones++;
        chk("clr_done_addr", 32'(mem_addr), 32'(WORDS_TB - 1));
        chk("clr_done_we", 32'(mem_we), 32'h1);
        chk("clr_busy_fall", 32'(clear_busy), 32'h0);
      end
      if (wr_ack) begin
        if (dones == 0) early_ack++;
        acked = 1'b1;
        wr_req = 1'b0;
      end
    end
    clear_req = 1'b0;
    repeat (6) begin
      tick();
      if (clear_done) dones++;
    end
    chk("clr_wr_acked", 32'(acked), 32'h1);
    chk("clr_early_ack", 32'(early_ack), 32'h0);
    chk("clr_done_count", 32'(dones), 32'h1);
    chk("clr_zero_writes", 32'(zeros), 32'(WORDS_TB));
    nz = 0;
    for (int i = 0; i < WORDS_TB; i++) if (i != 5 && ram[i] != 8'h00) nz++;
    chk("clr_nonzero_words", 32'(nz), 32'h0);
    chk("clr_ram_5", 32'(ram[5]), 32'hFF);

    // reset mid-clear and mid-line
    h = 300; v = 20;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (50) tick();
    chk("mid_busy", 32'(clear_busy), 32'h1);
    #2;
    reset = 1'b1;
    sb_en = 1'b0;
    sb.delete();
    #1;
    chk_reset_vals("arst");
    repeat (2) tick();
    reset = 1'b0;
    dones = 0; busy_seen = 0;
    repeat (30) begin
      tick();
      if (clear_done) dones++;
      if (clear_busy) busy_seen++;
    end
    chk("arst_no_done", 32'(dones), 32'h0);
    chk("arst_no_busy", 32'(busy_seen), 32'h0);

    // next frame fetches normally
    for (int i = 0; i < 2 * FA_LINE_STRIDE; i++) ram[i] = 8'(i * 53 + 7);
    ram[0] = 8'hA5;
    ram[1] = 8'h3C;
    h = 0; v = 0; sb_en = 1'b1;
    repeat (700) tick();
    sb_en = 1'b0;
    repeat (5) tick();
    chk("sb_drained", 32'(sb.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
